// File: rtl/nic_host_ctrl.sv
// nic_host_ctrl: processor-side master for one node of a 4-node ring NIC.
// Turns send requests into 64-bit ring packets, writes them to the NIC output
// buffer once it is free, and polls/reads arrived packets out to a
// valid/ready consumer port.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   tx_valid/tx_ready/tx_dest/tx_data send request handshake and payload
//   tx_err                            request to self dropped (1-cycle pulse)
//   tx_stall                          output buffer busy for POLL_LIMIT polls
//   rx_valid/rx_ready/rx_src/rx_vc/rx_data  received packet handshake
//   tx_count, rx_count                wrapping packet counters
//   nic_addr/nic_d_in/nic_d_out/nic_en/nic_wr_en  NIC register port
// Packet bits are numbered [0:63] with bit 0 as the MSB.
module nic_host_ctrl #(
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned POLL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [1:0]  tx_dest,
  input  logic [31:0] tx_data,
  output logic        tx_err,
  output logic        tx_stall,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [1:0]  rx_src,
  output logic        rx_vc,
  output logic [31:0] rx_data,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
  output logic [1:0]  nic_addr,
  output logic [0:63] nic_d_in,
  input  logic [0:63] nic_d_out,
  output logic        nic_en,
  output logic        nic_wr_en
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BUSY_W = 8;
  localparam int unsigned PKT_W  = 64;
  localparam logic [1:0]        NODE     = 2'(NODE_ID);
  localparam logic [BUSY_W-1:0] BUSY_LIM = BUSY_W'(POLL_LIMIT);

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_POLL,
    S_TX_WRITE,
    S_RX_POLL,
    S_RX_READ
  } state_e;

  state_e            state_q, state_d;
  logic [0:PKT_W-1]  pkt_q, pkt_d;
  logic              rr_q, rr_d;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic              rx_valid_q, rx_valid_d;
  logic [1:0]        rx_src_q, rx_src_d;
  logic              rx_vc_q, rx_vc_d;
  logic [31:0]       rx_data_q, rx_data_d;

  logic [1:0]        dist_c;
  logic              dir_c;
  logic [7:0]        hop_c;
  logic [0:PKT_W-1]  pkt_c;
  logic              pick_tx_c;

  // Ring routing: shortest direction and hop thermometer from (dest - self) mod 4.
  assign dist_c = tx_dest - NODE;

  always_comb begin
    dir_c = 1'b0;
    hop_c = 8'h00;
    case (dist_c)
      2'd1:    hop_c = 8'h01;
      2'd2:    hop_c = 8'h03;
      2'd3:    begin dir_c = 1'b1; hop_c = 8'h01; end
      default: ;
    endcase
  end

  assign pkt_c = {NODE[1], dir_c, 6'b0, hop_c, 14'b0, NODE, tx_data};

  // TX wins in IDLE when it is the only candidate or it is TX's turn.
  assign pick_tx_c = tx_valid && (rx_valid_q || !rr_q);

  // Next-state and NIC access decode.
  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    rr_d       = rr_q;
    busy_d     = busy_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    rx_valid_d = rx_valid_q;
    rx_src_d   = rx_src_q;
    rx_vc_d    = rx_vc_q;
    rx_data_d  = rx_data_q;
    tx_ready   = 1'b0;
    tx_err     = 1'b0;
    nic_en     = 1'b0;
    nic_wr_en  = 1'b0;
    nic_addr   = ADDR_IN_BUF;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_tx_c) begin
          rr_d = 1'b1;
          if (dist_c == 2'd0) begin
            // Send to self is dropped without touching the NIC.
            tx_err   = 1'b1;
            tx_ready = 1'b1;
          end else begin
            pkt_d   = pkt_c;
            state_d = S_TX_POLL;
          end
        end else if (!rx_valid_q) begin
          rr_d    = 1'b0;
          state_d = S_RX_POLL;
        end
      end
      S_TX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_OUT_STAT;
        if (nic_d_out == '0) begin
          state_d = S_TX_WRITE;
        end else begin
          if (busy_q != BUSY_LIM) busy_d = busy_q + BUSY_W'(1);
          state_d = S_IDLE;
        end
      end
      S_TX_WRITE: begin
        nic_en    = 1'b1;
        nic_wr_en = 1'b1;
        nic_addr  = ADDR_OUT_BUF;
        tx_ready  = 1'b1;
        tx_cnt_d  = tx_cnt_q + CNT_W'(1);
        busy_d    = '0;
        state_d   = S_IDLE;
      end
      S_RX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_STAT;
        state_d  = nic_d_out[63] ? S_RX_READ : S_IDLE;
      end
      S_RX_READ: begin
        nic_en     = 1'b1;
        nic_addr   = ADDR_IN_BUF;
        rx_src_d   = nic_d_out[30:31];
        rx_vc_d    = nic_d_out[0];
        rx_data_d  = nic_d_out[32:63];
        rx_valid_d = 1'b1;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pkt_q      <= '0;
      rr_q       <= 1'b0;
      busy_q     <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_src_q   <= '0;
      rx_vc_q    <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_src_q   <= rx_src_d;
      rx_vc_q    <= rx_vc_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign tx_stall = (busy_q == BUSY_LIM);
  assign rx_valid = rx_valid_q;
  assign rx_src   = rx_src_q;
  assign rx_vc    = rx_vc_q;
  assign rx_data  = rx_data_q;
  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
  assign nic_d_in = pkt_q;

endmodule

// File: tb/tb_nic_host_ctrl.sv
// tb_nic_host_ctrl: bench for nic_host_ctrl. A main instance (node 1, poll
// limit 4) is checked every cycle against a transaction-level model; two
// extra instances (nodes 2 and 0) pin packet formatting for other nodes.
module tb_nic_host_ctrl;

  localparam int MAIN_NODE = 1;
  localparam int MAIN_PL   = 4;

  // NIC accesses the model expects in the current cycle.
  localparam int A_NONE     = 0;
  localparam int A_OUT_STAT = 1;
  localparam int A_OUT_BUF  = 2;
  localparam int A_IN_STAT  = 3;
  localparam int A_IN_BUF   = 4;

  int checks   = 0;
  int failures = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        tx_valid = 1'b0;
  logic [1:0]  tx_dest = 2'd0;
  logic [31:0] tx_data = 32'd0;
  logic        rx_ready = 1'b0;
  logic        tx_ready, tx_err, tx_stall, rx_valid, rx_vc, nic_en, nic_wr_en;
  logic [1:0]  rx_src, nic_addr;
  logic [31:0] rx_data;
  logic [15:0] tx_count, rx_count;
  logic [0:63] nic_d_in, nic_d_out;

  // NIC register contents presented by the bench.
  logic [0:63] out_status = 64'h1;
  logic [0:63] in_status  = 64'h0;
  logic [0:63] in_buf     = 64'h0;
  logic [0:63] zero64     = 64'h0;

  always #5 clk = ~clk;

  always_comb begin
    case (nic_addr)
      2'b00:   nic_d_out = in_buf;
      2'b01:   nic_d_out = in_status;
      2'b11:   nic_d_out = out_status;
      default: nic_d_out = 64'h0;
    endcase
  end

  nic_host_ctrl #(.NODE_ID(MAIN_NODE), .POLL_LIMIT(MAIN_PL)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_data(tx_data),
    .tx_err(tx_err), .tx_stall(tx_stall),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_vc(rx_vc), .rx_data(rx_data),
    .tx_count(tx_count), .rx_count(rx_count),
    .nic_addr(nic_addr), .nic_d_in(nic_d_in), .nic_d_out(nic_d_out),
    .nic_en(nic_en), .nic_wr_en(nic_wr_en)
  );

  // Extra instances: x[0] is node 2, x[1] is node 0; NIC always free, nothing to receive.
  logic        xv [2];
  logic        x_ready [2], x_err [2], x_stall [2], x_rxv [2], x_vc [2], x_en [2], x_wr [2];
  logic [1:0]  x_src [2], x_addr [2];
  logic [31:0] x_rdata [2];
  logic [15:0] x_txc [2], x_rxc [2];
  logic [0:63] x_din [2];

  for (genvar g = 0; g < 2; g++) begin : g_extra
    nic_host_ctrl #(.NODE_ID((g == 0) ? 2 : 0), .POLL_LIMIT(16)) u_x (
      .clk(clk), .reset_n(reset_n),
      .tx_valid(xv[g]), .tx_ready(x_ready[g]), .tx_dest(tx_dest), .tx_data(tx_data),
      .tx_err(x_err[g]), .tx_stall(x_stall[g]),
      .rx_valid(x_rxv[g]), .rx_ready(1'b0), .rx_src(x_src[g]), .rx_vc(x_vc[g]), .rx_data(x_rdata[g]),
      .tx_count(x_txc[g]), .rx_count(x_rxc[g]),
      .nic_addr(x_addr[g]), .nic_d_in(x_din[g]), .nic_d_out(zero64),
      .nic_en(x_en[g]), .nic_wr_en(x_wr[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ring packet from the routing rules, using plain arithmetic.
  function automatic logic [0:63] build_pkt(input int node, input int dest, input logic [31:0] data);
    logic [0:63] p;
    int d;
    d = (dest - node + 4) % 4;
    p = '0;
    p[0]      = ((node / 2) % 2) == 1;
    p[1]      = (d == 3);
    p[8:15]   = (d == 2) ? 8'h03 : 8'h01;
    p[16:31]  = 16'(node);
    p[32:63]  = data;
    return p;
  endfunction

  function automatic logic [1:0] acc_addr(input int a);
    case (a)
      A_OUT_STAT: return 2'b11;
      A_OUT_BUF:  return 2'b10;
      A_IN_STAT:  return 2'b01;
      default:    return 2'b00;
    endcase
  endfunction

  // ---------------- behavioural model of the main instance ----------------
  int          m_acc   = A_NONE;
  logic [0:63] m_pkt   = '0;
  bit          m_turn_rx = 1'b0;   // 1: RX goes first when both want the NIC
  int          m_busy  = 0;
  bit          m_rxv   = 1'b0;
  logic [1:0]  m_src   = '0;
  bit          m_vc    = 1'b0;
  logic [31:0] m_rdata = '0;
  int          m_txc   = 0;
  int          m_rxc   = 0;
  bit          m_clr;

  function automatic bit model_tx_wins();
    return (m_acc == A_NONE) && tx_valid && (m_rxv || !m_turn_rx);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_acc = A_NONE; m_pkt = '0; m_turn_rx = 1'b0; m_busy = 0; m_rxv = 1'b0;
      m_src = '0; m_vc = 1'b0; m_rdata = '0; m_txc = 0; m_rxc = 0;
    end else begin
      m_clr = m_rxv && rx_ready;
      case (m_acc)
        A_NONE: begin
          if (model_tx_wins()) begin
            m_turn_rx = 1'b1;
            if (int'(tx_dest) != MAIN_NODE) begin
              m_pkt = build_pkt(MAIN_NODE, int'(tx_dest), tx_data);
              m_acc = A_OUT_STAT;
            end
          end else if (!m_rxv) begin
            m_turn_rx = 1'b0;
            m_acc = A_IN_STAT;
          end
        end
        A_OUT_STAT: begin
          if (out_status == 64'h0) m_acc = A_OUT_BUF;
          else begin
            if (m_busy < MAIN_PL) m_busy++;
            m_acc = A_NONE;
          end
        end
        A_OUT_BUF: begin
          m_txc = (m_txc + 1) % 65536; m_busy = 0; m_acc = A_NONE;
        end
        A_IN_STAT: m_acc = in_status[63] ? A_IN_BUF : A_NONE;
        default: begin
          m_src = in_buf[30:31]; m_vc = in_buf[0]; m_rdata = in_buf[32:63];
          m_rxv = 1'b1; m_rxc = (m_rxc + 1) % 65536; m_acc = A_NONE;
        end
      endcase
      if (m_clr) m_rxv = 1'b0;
    end
  end

  // Per-cycle comparison, mid-cycle.
  bit exp_err;
  always @(negedge clk) begin
    exp_err = model_tx_wins() && (int'(tx_dest) == MAIN_NODE);
    chk("cmp_nic_en",    64'(nic_en),    64'(m_acc != A_NONE));
    chk("cmp_nic_wr_en", 64'(nic_wr_en), 64'(m_acc == A_OUT_BUF));
    chk("cmp_nic_addr",  64'(nic_addr),  64'(acc_addr(m_acc)));
    chk("cmp_nic_d_in",  nic_d_in,       m_pkt);
    chk("cmp_tx_ready",  64'(tx_ready),  64'((m_acc == A_OUT_BUF) || exp_err));
    chk("cmp_tx_err",    64'(tx_err),    64'(exp_err));
    chk("cmp_tx_stall",  64'(tx_stall),  64'(m_busy == MAIN_PL));
    chk("cmp_rx_valid",  64'(rx_valid),  64'(m_rxv));
    chk("cmp_rx_src",    64'(rx_src),    64'(m_src));
    chk("cmp_rx_vc",     64'(rx_vc),     64'(m_vc));
    chk("cmp_rx_data",   64'(rx_data),   64'(m_rdata));
    chk("cmp_tx_count",  64'(tx_count),  64'(m_txc));
    chk("cmp_rx_count",  64'(rx_count),  64'(m_rxc));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  function automatic bit cond(input int k);
    case (k)
      0: return nic_en && (nic_addr == 2'b11);
      1: return tx_stall;
      2: return nic_wr_en;
      3: return rx_valid;
      4: return tx_err;
      5: return x_wr[0];
      default: return x_wr[1];
    endcase
  endfunction

  task automatic wait_cond(input int k, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!cond(k) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n < 60), 64'd1);
  endtask

  int tx_n, rx_n, last;
  bit bad;

  initial begin
    xv[0] = 1'b0;
    xv[1] = 1'b0;
    chk("model_pkt_pin", build_pkt(1, 0, 32'hDEADBEEF), 64'h4001_0001_DEAD_BEEF);
    chk("model_pkt_pin2", build_pkt(2, 0, 32'h2), 64'h8003_0002_0000_0002);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_count", 64'(tx_count), 64'd0);
    chk("rst_nic_en",   64'(nic_en),   64'd0);
    chk("rst_nic_d_in", nic_d_in,      64'd0);

    // Reset in the middle of an output-status poll, then restart.
    #1 reset_n = 1'b1;
    tx_valid = 1'b1; tx_dest = 2'd0; tx_data = 32'hDEADBEEF;
    wait_cond(0, "t1_wait_txpoll");
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("t1_rst_en",    64'(nic_en),   64'd0);
    chk("t1_rst_ready", 64'(tx_ready), 64'd0);
    chk("t1_rst_din",   nic_d_in,      64'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("t1_restart_txpoll", 64'({nic_en, nic_addr}), 64'b111);

    // Busy output buffer until stall, then free it.
    wait_cond(1, "t4_wait_stall");
    chk("t4_stall",       64'(tx_stall), 64'd1);
    chk("t4_count_zero",  64'(tx_count), 64'd0);
    #1 out_status = 64'h0;
    wait_cond(2, "t2_wait_write");
    chk("t2_pkt",   nic_d_in,             64'h4001_0001_DEAD_BEEF);
    chk("t2_ready", 64'(tx_ready),        64'd1);
    chk("t2_addr",  64'(nic_addr),        64'd2);
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk);
    chk("t4_ready_pulse", 64'(tx_ready), 64'd0);
    chk("t4_stall_clear", 64'(tx_stall), 64'd0);
    chk("t4_count_one",   64'(tx_count), 64'd1);

    // Two-hop destination.
    #1 tx_valid = 1'b1; tx_dest = 2'd3; tx_data = 32'h1234_5678;
    wait_cond(2, "t3_wait_write_d2");
    chk("t3_pkt_d2", nic_d_in, 64'h0003_0001_1234_5678);
    @(posedge clk); #1 tx_valid = 1'b0;

    // Receive and hold while the consumer is not ready.
    in_buf = 64'h4001_0003_0000_00AB; in_status = 64'h1; rx_ready = 1'b0;
    wait_cond(3, "t5_wait_rx");
    chk("t5_src",   64'(rx_src),   64'd3);
    chk("t5_data",  64'(rx_data),  64'hAB);
    chk("t5_vc",    64'(rx_vc),    64'd0);
    chk("t5_count", 64'(rx_count), 64'd1);
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (nic_en && nic_addr == 2'b01) bad = 1'b1;
    end
    chk("t5_no_poll_held", 64'(bad), 64'd0);
    #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("t5_rx_cleared", 64'(rx_valid), 64'd0);
    wait_cond(3, "t5_wait_rx2");
    chk("t5_count2", 64'(rx_count), 64'd2);
    #1 in_status = 64'h0; rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;

    // TX and RX both eligible: polls must alternate.
    out_status = 64'h1; tx_dest = 2'd2; tx_data = 32'hA5A5_0F0F; tx_valid = 1'b1;
    tx_n = 0; rx_n = 0; last = -1; bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (nic_en && (nic_addr == 2'b11 || nic_addr == 2'b01)) begin
        if (int'(nic_addr) == last) bad = 1'b1;
        last = int'(nic_addr);
        if (nic_addr == 2'b11) tx_n++; else rx_n++;
      end
    end
    chk("t6_alternate", 64'(bad), 64'd0);
    chk("t6_tx_polls",  64'(tx_n >= 8), 64'd1);
    chk("t6_rx_polls",  64'(rx_n >= 8), 64'd1);
    chk("t6_stall",     64'(tx_stall),  64'd1);
    #1 out_status = 64'h0;
    wait_cond(2, "t6_wait_write");
    chk("t6_pkt_d1", nic_d_in, 64'h0001_0001_A5A5_0F0F);
    @(posedge clk); #1 tx_valid = 1'b0;

    // Send to self is dropped.
    tx_dest = 2'd1; tx_valid = 1'b1;
    wait_cond(4, "t6_wait_err");
    chk("t6_err_ready", 64'(tx_ready), 64'd1);
    chk("t6_err_no_nic", 64'(nic_en),  64'd0);
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk);
    chk("t6_err_pulse", 64'(tx_err),   64'd0);
    chk("t6_count",     64'(tx_count), 64'd3);

    // Other node IDs.
    #1 tx_dest = 2'd0; tx_data = 32'h2; xv[0] = 1'b1;
    wait_cond(5, "t3_wait_node2");
    chk("t3_node2_pkt",   x_din[0],        64'h8003_0002_0000_0002);
    chk("t3_node2_ready", 64'(x_ready[0]), 64'd1);
    @(posedge clk); #1 xv[0] = 1'b0;
    tx_dest = 2'd1; xv[1] = 1'b1;
    wait_cond(6, "t3_wait_node0");
    chk("t3_node0_hdr", 64'(x_din[1][0:15]), 64'h0001);
    chk("t3_node0_pkt", x_din[1],            64'h0001_0000_0000_0002);
    @(posedge clk); #1 xv[1] = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
